// File: rtl/acc_requant.sv
// Accumulator requantizer: round-half-up arithmetic shift, saturation to 16 bits,
// and a small output FIFO whose admission accounts for samples still in the pipe.
module acc_requant #(
  parameter int SHIFT = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [31:0]         in_acc,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic signed [15:0]         out_data,
  input  logic                       out_ready,
  output logic                       sat_flag,
  input  logic                       clr_sat,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW:0] DEPTH_V = DEPTH[LW:0];

  function automatic logic signed [32:0] round_shift(input logic signed [31:0] acc);
    logic signed [32:0] ext;
    ext = {acc[31], acc} + (33'sd1 <<< (SHIFT - 1));
    return ext >>> SHIFT;
  endfunction

  function automatic logic is_sat(input logic signed [32:0] r);
    return (r > 33'sd32767) || (r < -33'sd32768);
  endfunction

  function automatic logic signed [15:0] saturate(input logic signed [32:0] r);
    if (r > 33'sd32767)
      return 16'sh7FFF;
    else if (r < -33'sd32768)
      return 16'sh8000;
    else
      return r[15:0];
  endfunction

  logic signed [32:0] r_p1;
  logic               vld_p1;
  logic signed [15:0] q_p2;
  logic               sat_p2;
  logic               vld_p2;

  logic signed [15:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               wr_en;
  logic               rd_en;
  logic [LW:0]        occ;

  // stage 1: widen and round
  always_ff @(posedge clk) begin
    r_p1 <= round_shift(in_acc);
    if (!rst)
      vld_p1 <= 1'b0;
    else
      vld_p1 <= in_valid && in_ready;
  end

  // stage 2: saturate, FIFO write happens on the following edge
  always_ff @(posedge clk) begin
    q_p2   <= saturate(r_p1);
    sat_p2 <= is_sat(r_p1);
    if (!rst)
      vld_p2 <= 1'b0;
    else
      vld_p2 <= vld_p1;
  end

  assign wr_en = vld_p2;
  assign rd_en = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= q_p2;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_en)
        rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // a saturating write overrides a coincident clear
      if (wr_en && sat_p2)
        sat_flag <= 1'b1;
      else if (clr_sat)
        sat_flag <= 1'b0;
    end
  end

  // count in-flight samples so the FIFO can never be overrun without a stall path
  assign occ       = {1'b0, level} + {{LW{1'b0}}, vld_p1} + {{LW{1'b0}}, vld_p2};
  assign in_ready  = rst && (occ < DEPTH_V);
  assign out_valid = rst && (level != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : 16'sd0;

endmodule

// File: tb/tb_acc_requant.sv
// Bench for acc_requant: directed and random traffic checked against a
// transaction-level model (fixed two-cycle latency into a FIFO queue).
module tb_acc_requant;
  localparam int SHIFT = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic signed [31:0]   in_acc;
  logic                 in_ready;
  logic                 out_valid;
  logic signed [15:0]   out_data;
  logic                 out_ready;
  logic                 sat_flag;
  logic                 clr_sat;
  logic [LW-1:0]        level;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int v;
    bit s;
    int due;
  } item_t;

  item_t inf_q[$];
  int    fifo_q[$];
  bit    m_sat;
  int    cyc;
  bit    acc_last;

  acc_requant #(.SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_acc(in_acc),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .sat_flag(sat_flag), .clr_sat(clr_sat),
    .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  // floor((a + 2^(SHIFT-1)) / 2^SHIFT), clamped to int16
  function automatic int ref_val(input int a, output bit s);
    longint d, v, q;
    d = longint'(1) << SHIFT;
    v = longint'(a) + d / 2;
    if (v >= 0) q = v / d;
    else        q = -((-v + d - 1) / d);
    s = 1'b0;
    if (q > 32767) begin q = 32767; s = 1'b1; end
    else if (q < -32768) begin q = -32768; s = 1'b1; end
    return int'(q);
  endfunction

  function automatic logic [31:0] rnd_acc();
    case ($urandom_range(0, 4))
      0: return $urandom;
      1: return 32'(int'($urandom_range(0, 16777215)) - 8388608);
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return 32'(int'($urandom_range(0, 1023)) - 512);
    endcase
  endfunction

  task automatic step(input bit v, input logic [31:0] a, input bit ordy, input bit clr, input bit r);
    bit    exp_rdy, do_rd, s;
    int    val;
    item_t it;
    in_valid = v; in_acc = a; out_ready = ordy; clr_sat = clr; rst = r;
    #1;
    exp_rdy = r && ((fifo_q.size() + inf_q.size()) < DEPTH);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, r && (fifo_q.size() != 0));
    chk("level", level, fifo_q.size());
    chk("sat_flag", sat_flag, m_sat);
    if (!r)
      chk("rst_out_data", out_data, 0);
    else if (fifo_q.size() != 0)
      chk("out_data", out_data, fifo_q[0]);
    acc_last = v && exp_rdy;
    do_rd    = r && (fifo_q.size() != 0) && ordy;
    @(posedge clk);
    #1;
    cyc++;
    if (!r) begin
      inf_q.delete();
      fifo_q.delete();
      m_sat = 1'b0;
    end else begin
      if (do_rd) void'(fifo_q.pop_front());
      if (inf_q.size() > 0 && inf_q[0].due == cyc) begin
        it = inf_q.pop_front();
        fifo_q.push_back(it.v);
        if (it.s) m_sat = 1'b1;
        else if (clr) m_sat = 1'b0;
      end else if (clr) begin
        m_sat = 1'b0;
      end
      if (acc_last) begin
        val = ref_val(int'(a), s);
        it.v = val; it.s = s; it.due = cyc + 2;
        inf_q.push_back(it);
      end
    end
  endtask

  initial begin
    int n;
    logic [LW-1:0] lvl0;
    rst = 1'b0; in_valid = 1'b0; in_acc = '0; out_ready = 1'b0; clr_sat = 1'b0;
    cyc = 0; m_sat = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset state, including a request presented while held in reset
    step(1, 32'h0000_1234, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_level", level, 0);

    // rounding example
    step(1, 32'h0001_2345, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    chk("round_valid", out_valid, 1);
    chk("round_data", out_data, 16'sh0123);
    chk("round_sat", sat_flag, 0);
    step(0, 0, 1, 0, 1);

    // negative rounding and both saturation directions
    step(1, -32'sd384, 0, 0, 1);
    step(1, 32'h7FFF_FFFF, 0, 0, 1);
    step(1, 32'h8000_0000, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("neg_level", level, 3);
    chk("neg_d0", out_data, -1);
    chk("neg_sat", sat_flag, 1);
    step(0, 0, 1, 0, 1);
    chk("pos_sat_d1", out_data, 32767);
    step(0, 0, 1, 0, 1);
    chk("neg_sat_d2", out_data, -32768);
    step(0, 0, 1, 0, 1);
    chk("neg_empty", level, 0);

    // clear without saturation, then clear coinciding with a saturating write
    step(0, 0, 1, 1, 1);
    chk("clr_plain", sat_flag, 0);
    step(1, 32'h7FFF_FFFF, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 1, 1);
    chk("clr_vs_set", sat_flag, 1);
    step(0, 0, 1, 1, 1);
    chk("clr_after", sat_flag, 0);
    step(0, 0, 1, 0, 1);

    // backpressure: exactly DEPTH accepted, then in-order drain
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, rnd_acc(), 0, 0, 1);
      n += int'(acc_last);
    end
    chk("bp_accepted", n, DEPTH);
    chk("bp_level", level, DEPTH);
    chk("bp_in_ready", in_ready, 0);
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 1, 0, 1);
    chk("bp_drained", level, 0);

    // full FIFO with both sides active: steady throughput across pointer wrap
    for (int i = 0; i < 8; i++) step(1, rnd_acc(), 0, 0, 1);
    lvl0 = '0;
    for (int i = 0; i < 20; i++) begin
      step(1, rnd_acc(), 1, 0, 1);
      if (i == 4) lvl0 = level;
      if (i > 4) begin
        chk("tput_level", level, lvl0);
        chk("tput_in_ready", in_ready, 1);
      end
    end
    for (int i = 0; i < DEPTH + 3; i++) step(0, 0, 1, 0, 1);

    // reset with three buffered entries
    step(1, 32'h7FFF_FFFF, 0, 0, 1);
    step(1, rnd_acc(), 0, 0, 1);
    step(1, rnd_acc(), 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("mid_level", level, 3);
    step(0, 0, 0, 0, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sat", sat_flag, 0);
    step(1, 32'h0001_2345, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    chk("post_rst_data", out_data, 16'sh0123);
    step(0, 0, 1, 0, 1);

    // random mixed traffic with occasional clears and resets
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), rnd_acc(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 63) != 0);
    for (int i = 0; i < DEPTH + 4; i++) step(0, 0, 1, 0, 1);
    chk("final_empty", level, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
